// File: rtl/shooter_pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shooter_pwm_pkg : shared constants and types for the PWM decoder     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package shooter_pwm_pkg;

  localparam int unsigned C_DATA_W          = 32;
  localparam int unsigned C_CNT_W           = $clog2(C_DATA_W);
  localparam int unsigned C_SCALE_DEFAULT   = 5;
  localparam int unsigned C_VEL_MAX_DEFAULT = 20000;
  localparam int unsigned C_TIMEOUT_DEFAULT = 200000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } meas_state_t;

  function automatic logic [C_DATA_W-1:0] clamp_u(
    input logic [C_DATA_W-1:0] i_val,
    input logic [C_DATA_W-1:0] i_lim
  );
    return (i_val > i_lim) ? i_lim : i_val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_divider : 32-bit unsigned restoring divider, one bit per cycle   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seq_divider
  import shooter_pwm_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [C_DATA_W-1:0] dividend,
  input  logic [C_DATA_W-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [C_DATA_W-1:0] quotient
);

  localparam logic [C_CNT_W-1:0] C_LAST_STEP = C_CNT_W'(C_DATA_W - 1);

  logic [C_DATA_W-1:0] r_rem;
  logic [C_DATA_W-1:0] r_quot;
  logic [C_DATA_W-1:0] r_div;
  logic [C_CNT_W-1:0]  r_cnt;
  logic                r_busy;
  logic                r_done;

  logic [C_DATA_W:0]   w_rem_sh;
  logic [C_DATA_W:0]   w_diff;
  logic                w_fits;

  // The dividend shifts out of r_quot while quotient bits shift in behind it.
  assign w_rem_sh = {r_rem, r_quot[C_DATA_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_fits   = ~w_diff[C_DATA_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_rem  <= w_fits ? w_diff[C_DATA_W-1:0] : w_rem_sh[C_DATA_W-1:0];
        r_quot <= {r_quot[C_DATA_W-2:0], w_fits};
        r_cnt  <= r_cnt + C_CNT_W'(1);
        if (r_cnt == C_LAST_STEP) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start) begin
        r_rem  <= '0;
        r_quot <= dividend;
        r_div  <= divisor;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_quot;

endmodule
`default_nettype wire

// File: rtl/shooter_pwm_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shooter_pwm_decoder : measures PWM high time and period, reports      |
// | velocity = min(high/SCALE, VEL_MAX) with loss-of-signal detection    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shooter_pwm_decoder
  import shooter_pwm_pkg::*;
#(
  parameter int unsigned SCALE   = C_SCALE_DEFAULT,
  parameter int unsigned VEL_MAX = C_VEL_MAX_DEFAULT,
  parameter int unsigned TIMEOUT = C_TIMEOUT_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [C_DATA_W-1:0] velocity,
  output logic [C_DATA_W-1:0] period,
  output logic                valid,
  output logic                signal_lost
);

  localparam logic [C_DATA_W-1:0] C_ONE     = C_DATA_W'(1);
  localparam logic [C_DATA_W-1:0] C_SCALE   = C_DATA_W'(SCALE);
  localparam logic [C_DATA_W-1:0] C_VEL_MAX = C_DATA_W'(VEL_MAX);
  localparam logic [C_DATA_W-1:0] C_TIMEOUT = C_DATA_W'(TIMEOUT);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_sync3;
  meas_state_t         r_state;
  logic [C_DATA_W-1:0] r_frame_cnt;
  logic [C_DATA_W-1:0] r_high_cnt;
  logic [C_DATA_W-1:0] r_lat_high;
  logic [C_DATA_W-1:0] r_lat_frame;
  logic                r_div_go;
  logic [C_DATA_W-1:0] r_velocity;
  logic [C_DATA_W-1:0] r_period;
  logic                r_valid;
  logic                r_signal_lost;

  logic                w_rise;
  logic                w_fall;
  logic                w_timeout;
  logic                w_div_busy;
  logic                w_div_done;
  logic                w_div_engaged;
  logic [C_DATA_W-1:0] w_quot;

  assign w_rise        = r_sync2 & ~r_sync3;
  assign w_fall        = ~r_sync2 & r_sync3;
  assign w_timeout     = (r_state != ST_IDLE) && (r_frame_cnt >= C_TIMEOUT);
  // A latched frame waiting for the divider to pick it up counts as busy too.
  assign w_div_engaged = r_div_go | w_div_busy;

  seq_divider u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (r_div_go),
    .dividend (r_lat_high),
    .divisor  (C_SCALE),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync3       <= 1'b0;
      r_state       <= ST_IDLE;
      r_frame_cnt   <= '0;
      r_high_cnt    <= '0;
      r_lat_high    <= '0;
      r_lat_frame   <= '0;
      r_div_go      <= 1'b0;
      r_velocity    <= '0;
      r_period      <= '0;
      r_valid       <= 1'b0;
      r_signal_lost <= 1'b1;
    end else begin
      r_sync1  <= pwm_in;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_div_go <= 1'b0;
      r_valid  <= 1'b0;

      // Timeout dominates a coincident rise and suppresses any result.
      if (w_timeout) begin
        r_state       <= ST_IDLE;
        r_frame_cnt   <= '0;
        r_high_cnt    <= '0;
        r_velocity    <= '0;
        r_signal_lost <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state     <= ST_HIGH;
              r_frame_cnt <= C_ONE;
              r_high_cnt  <= C_ONE;
            end
          end
          ST_HIGH: begin
            r_frame_cnt <= r_frame_cnt + C_ONE;
            if (r_sync2) begin
              r_high_cnt <= r_high_cnt + C_ONE;
            end
            if (w_fall) begin
              r_state <= ST_LOW;
            end
          end
          ST_LOW: begin
            if (w_rise) begin
              r_state     <= ST_HIGH;
              r_frame_cnt <= C_ONE;
              r_high_cnt  <= C_ONE;
              if (!w_div_engaged) begin
                r_lat_high  <= r_high_cnt;
                r_lat_frame <= r_frame_cnt;
                r_div_go    <= 1'b1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + C_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase

        if (w_div_done) begin
          r_velocity    <= clamp_u(w_quot, C_VEL_MAX);
          r_period      <= r_lat_frame;
          r_valid       <= 1'b1;
          r_signal_lost <= 1'b0;
        end
      end
    end
  end

  assign velocity    = r_velocity;
  assign period      = r_period;
  assign valid       = r_valid;
  assign signal_lost = r_signal_lost;

endmodule
`default_nettype wire

// File: doc/shooter_pwm_decoder.md
SHOOTER_PWM_DECODER -- requirements
Module: shooter_pwm_decoder

Interface
REQ-001 Parameter SCALE, default 5: clock cycles of high time per velocity unit.
REQ-002 Parameter VEL_MAX, default 20000: velocity clamp ceiling.
REQ-003 Parameter TIMEOUT, default 200000: maximum cycles allowed between rising edges.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clock  input  1  system clock, all state on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 pwm_in  input  1  asynchronous PWM input from the shooter motor/ESC line.
REQ-008 velocity  output  32  decoded velocity, 0..VEL_MAX.
REQ-009 period  output  32  last measured frame length in cycles, rising edge to rising edge.
REQ-010 valid  output  1  one-cycle strobe when velocity/period update.
REQ-011 signal_lost  output  1  high while no valid frame is present.

Function
REQ-012 pwm_in SHALL pass through a 2-flop synchronizer; rise/fall detection SHALL use the synchronized signal only.
REQ-013 Measurement FSM states SHALL be IDLE, HIGH, LOW.
- IDLE->HIGH on rise.
- HIGH->LOW on fall.
- LOW->HIGH on rise; that rise completes a frame.
REQ-014 frame_cnt SHALL reset to 1 on every rise and increment every cycle; high_cnt SHALL count synchronized-high cycles since the last rise.
REQ-015 On frame completion, high_cnt and frame_cnt SHALL be latched and a divide of high_cnt by SCALE started.
REQ-016 A rise out of IDLE SHALL start measurement only; it SHALL produce no output.
REQ-017 velocity SHALL equal min(floor(high_cnt/SCALE), VEL_MAX).
REQ-018 period SHALL equal the latched frame_cnt.
REQ-019 velocity, period and valid SHALL update together, exactly 36 cycles after the clock edge that first samples pwm_in high.
- Budget: 2 synchronizer + 1 edge detect + 1 latch + 32 divider cycles.
REQ-020 valid SHALL be high for exactly one cycle per completed frame.
REQ-021 If a frame completes while the divider is busy, that frame SHALL be dropped, the running divide SHALL finish unaffected, and measurement SHALL continue.
REQ-022 If frame_cnt reaches TIMEOUT in any non-IDLE state (line stuck high or low), the FSM SHALL:
- go to IDLE;
- set signal_lost=1;
- force velocity=0;
- leave period unchanged;
- not pulse valid.
REQ-023 signal_lost SHALL clear on the same cycle as the next valid strobe.
REQ-024 Counters SHALL never wrap; TIMEOUT bounds them below 2^32.
REQ-025 A rise and a timeout on the same cycle SHALL be treated as timeout.

Reset
REQ-026 While reset is high:
- FSM=IDLE;
- counters, synchronizer and divider cleared;
- velocity=0, period=0, valid=0, signal_lost=1.
REQ-027 Reset asserted mid-frame or mid-divide SHALL abort the operation, with no valid strobe afterwards.
REQ-028 After reset release, the first output SHALL require a full rise-fall-rise frame.

Structure
REQ-029 Package shooter_pwm_pkg SHALL hold:
- SCALE, VEL_MAX, TIMEOUT defaults;
- the measurement FSM state enum;
- the 32-bit width constant.
REQ-030 Division SHALL live in sub-module seq_divider: 32-bit unsigned restoring divider.
- Ports: start, dividend, divisor, busy, done, quotient.
- Exactly 32 cycles from start to done.

Verification
REQ-031 Frames of 50000 high / 100002 period, repeated -> velocity=10000, period=100002, one valid per frame, signal_lost=0 after first update.
REQ-032 Frames of 110000 high / 150000 period -> velocity=20000 (clamped), period=150000.
REQ-033 pwm_in held low for 200000 cycles after valid frames -> signal_lost=1, velocity=0, no valid; next full frame restores output.
REQ-034 1-cycle high glitch with 100002 period -> velocity=0, valid pulses; second rise within 20 cycles of a completion -> that frame dropped, first result intact.
REQ-035 Reset asserted 30000 cycles into a high phase and during a divide -> all outputs at reset values, no valid until two rises after release.
REQ-036 Loopback from the team's shooter PWM generator with velocity 12000 -> decoded velocity 12000 +/-1, valid latency 36 cycles from rise.
